// File: rtl/lsu.sv
// Load/store unit for the 16-bit two-stage core.
// Accepts ldr/str from the pipeline, runs one valid/ready transaction on the
// data-memory port at a time, and pulses load results back to writeback.
// Optional build macro LSU_ALIGN_CHECK_EN adds a 'fault' output and rejects
// ldr/str with an odd address without touching memory.

module lsu #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [TAGW-1:0]  req_rd,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             wb_valid,
    output logic [TAGW-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             busy
`ifdef LSU_ALIGN_CHECK_EN
    ,
    output logic             fault
`endif
);

    localparam logic [3:0] OP_LDR = 4'b1100;
    localparam logic [3:0] OP_STR = 4'b1101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [TAGW-1:0]  rd_q, rd_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [TAGW-1:0]  wb_rd_q, wb_rd_d;
    logic             misalign_q, misalign_d;

    logic             isMemOp;
    logic             misaligned;

    assign isMemOp = (req_op == OP_LDR) || (req_op == OP_STR);

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // Next-state logic: latch the request in IDLE, walk the handshake, capture load data.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        we_d       = we_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (req_valid && isMemOp) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    we_d       = (req_op == OP_STR);
                    misalign_d = misaligned;
                    state_d    = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wb_data_d = mem_rdata;
                    wb_rd_d   = rd_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            misalign_q <= misalign_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_valid = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = (state_q == RESP) && !misalign_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

`ifdef LSU_ALIGN_CHECK_EN
    assign fault = (state_q == RESP) && misalign_q;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized
// transactions checked against a word-addressed memory model and the
// handshake/latency rules of the load/store unit.

module tb_lsu;

    localparam int W = 16;
    localparam int T = 4;
    localparam logic [3:0] LDR = 4'b1100;
    localparam logic [3:0] STR = 4'b1101;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic [T-1:0] req_rd;
    logic         mem_valid;
    logic         mem_ready;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_rvalid;
    logic [W-1:0] mem_rdata;
    logic         wb_valid;
    logic [T-1:0] wb_rd;
    logic [W-1:0] wb_data;
    logic         busy;
`ifdef LSU_ALIGN_CHECK_EN
    logic         fault;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] memModel [logic [W-1:0]];

    lsu #(.WIDTH(W), .TAGW(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy)
`ifdef LSU_ALIGN_CHECK_EN
        ,
        .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset values while reset is held and just after release.
    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid got %b exp 0", mem_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h exp 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata got %h exp 0000", mem_wdata); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %b exp 0", wb_valid); end
        checks++; if (wb_rd !== 4'h0) begin errors++; $display("[TB] FAIL reset_wb_rd got %h exp 0", wb_rd); end
        checks++; if (wb_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_wb_data got %h exp 0000", wb_data); end
`ifdef LSU_ALIGN_CHECK_EN
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b exp 0", fault); end
`endif
        rst = 1'b0;
        tick;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req_ready got %b exp 1", req_ready); end
    endtask

    // One full transaction, checked cycle by cycle against the handshake rules.
    task automatic do_txn(input string tag, input logic [3:0] op, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, input logic [T-1:0] rd,
                          input int stall, input int rdelay);
        logic isLd, isSt, bad;
        logic [W-1:0] expData;
        int waitCnt;
        isLd = (op == LDR);
        isSt = (op == STR);
        bad  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        bad  = (isLd || isSt) && addr[0];
`endif
        waitCnt = 0;
        while (req_ready !== 1'b1 && waitCnt < 20) begin tick; waitCnt++; end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s ready_timeout got %b exp 1", tag, req_ready); end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        tick;
        req_valid = 1'b0; req_op = 4'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
        if (!(isLd || isSt)) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s nop_busy got %b exp 0", tag, busy); end
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s nop_mem_valid got %b exp 0", tag, mem_valid); end
            return;
        end
        if (bad) begin
`ifdef LSU_ALIGN_CHECK_EN
            checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL %s fault_pulse got %b exp 1", tag, fault); end
`endif
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s fault_wb_valid got %b exp 0", tag, wb_valid); end
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s fault_mem_valid got %b exp 0", tag, mem_valid); end
            tick;
`ifdef LSU_ALIGN_CHECK_EN
            checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL %s fault_clear got %b exp 0", tag, fault); end
`endif
            checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s fault_ready got %b exp 1", tag, req_ready); end
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s fault_mem_valid2 got %b exp 0", tag, mem_valid); end
            return;
        end
        for (int i = 0; i <= stall; i++) begin
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s req_mem_valid got %b exp 1", tag, mem_valid); end
            checks++; if (mem_addr !== addr) begin errors++; $display("[TB] FAIL %s req_mem_addr got %h exp %h", tag, mem_addr, addr); end
            checks++; if (mem_we !== isSt) begin errors++; $display("[TB] FAIL %s req_mem_we got %b exp %b", tag, mem_we, isSt); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s req_ready_busy got %b exp 0", tag, req_ready); end
            if (isSt) begin
                checks++; if (mem_wdata !== wdata) begin errors++; $display("[TB] FAIL %s req_mem_wdata got %h exp %h", tag, mem_wdata, wdata); end
            end
            mem_ready = (i == stall);
            tick;
        end
        mem_ready = 1'b0;
        if (isSt) begin
            memModel[addr] = wdata;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s st_done_ready got %b exp 1", tag, req_ready); end
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s st_done_mem_valid got %b exp 0", tag, mem_valid); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s st_wb_valid got %b exp 0", tag, wb_valid); end
            return;
        end
        if (!memModel.exists(addr)) memModel[addr] = 16'($urandom);
        expData = memModel[addr];
        for (int i = 0; i < rdelay; i++) begin
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s wait_mem_valid got %b exp 0", tag, mem_valid); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s wait_busy got %b exp 1", tag, busy); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s wait_wb_valid got %b exp 0", tag, wb_valid); end
            tick;
        end
        mem_rvalid = 1'b1; mem_rdata = expData;
        tick;
        mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s resp_wb_valid got %b exp 1", tag, wb_valid); end
        checks++; if (wb_rd !== rd) begin errors++; $display("[TB] FAIL %s resp_wb_rd got %h exp %h", tag, wb_rd, rd); end
        checks++; if (wb_data !== expData) begin errors++; $display("[TB] FAIL %s resp_wb_data got %h exp %h", tag, wb_data, expData); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s resp_mem_valid got %b exp 0", tag, mem_valid); end
`ifdef LSU_ALIGN_CHECK_EN
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL %s resp_fault got %b exp 0", tag, fault); end
`endif
        tick;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s pulse_len got %b exp 0", tag, wb_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s ld_done_ready got %b exp 1", tag, req_ready); end
        checks++; if (wb_data !== expData) begin errors++; $display("[TB] FAIL %s wb_data_hold got %h exp %h", tag, wb_data, expData); end
    endtask

    // Store with memory always ready, then read the same word back.
    task automatic test_store;
        do_txn("store", STR, 16'h0040, 16'hBEEF, 4'h0, 0, 0);
        do_txn("store_readback", LDR, 16'h0040, 16'h0000, 4'h3, 0, 0);
    endtask

    // Load with request backpressure and delayed read data.
    task automatic test_load_backpressure;
        memModel[16'h1234] = 16'hA55A;
        do_txn("load_bp", LDR, 16'h1234, 16'h0000, 4'h5, 3, 1);
    endtask

    // Non-memory op held valid: nothing should happen.
    task automatic test_nonmem;
        req_valid = 1'b1; req_op = 4'b0001; req_addr = 16'h0010; req_rd = 4'h1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL nonmem_mem_valid got %b exp 0", mem_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL nonmem_ready got %b exp 1", req_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nonmem_busy got %b exp 0", busy); end
        end
        req_valid = 1'b0;
    endtask

    // ldr then str with req_valid held high; the str must wait for IDLE.
    task automatic test_back_to_back;
        memModel[16'h0100] = 16'h1111;
        mem_ready = 1'b1;
        req_valid = 1'b1; req_op = LDR; req_addr = 16'h0100; req_rd = 4'h7;
        tick;
        req_op = STR; req_addr = 16'h0200; req_wdata = 16'h2222;
        checks++; if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100) begin errors++; $display("[TB] FAIL b2b_ld_req got v%b we%b a%h exp v1 we0 a0100", mem_valid, mem_we, mem_addr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_req got %b exp 0", req_ready); end
        tick;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wait_mem_valid got %b exp 0", mem_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_wait got %b exp 0", req_ready); end
        mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h1111 || wb_rd !== 4'h7) begin errors++; $display("[TB] FAIL b2b_resp got v%b d%h rd%h exp v1 d1111 rd7", wb_valid, wb_data, wb_rd); end
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_resp_idle got v%b r%b exp v0 r0", mem_valid, req_ready); end
        tick;
        checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got r%b v%b wb%b exp r1 v0 wb0", req_ready, mem_valid, wb_valid); end
        tick;
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h2222) begin errors++; $display("[TB] FAIL b2b_st_req got v%b we%b a%h d%h exp v1 we1 a0200 d2222", mem_valid, mem_we, mem_addr, mem_wdata); end
        tick;
        memModel[16'h0200] = 16'h2222;
        mem_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_st_done got r%b v%b exp r1 v0", req_ready, mem_valid); end
    endtask

    // Asynchronous reset while a load waits for data; stale rvalid is ignored.
    task automatic test_reset_midop;
        memModel[16'h0300] = 16'h3333;
        mem_ready = 1'b1;
        req_valid = 1'b1; req_op = LDR; req_addr = 16'h0300; req_rd = 4'h2;
        tick;
        req_valid = 1'b0;
        tick;
        mem_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midop_busy_before got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || mem_valid !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midop_async got b%b v%b wb%b r%b exp b0 v0 wb0 r1", busy, mem_valid, wb_valid, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== 16'h0000) begin errors++; $display("[TB] FAIL midop_stale_rvalid got wb%b b%b d%h exp wb0 b0 d0000", wb_valid, busy, wb_data); end
        do_txn("after_reset", LDR, 16'h0300, 16'h0000, 4'h2, 1, 0);
    endtask

    // Random mix of loads, stores and no-ops with random stalls.
    task automatic test_random;
        logic [3:0] op;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) op = LDR;
            else if (r < 9) op = STR;
            else op = 4'($urandom_range(0, 11));
            do_txn("random", op, 16'h0800 + 16'($urandom_range(0, 31)), 16'($urandom),
                   4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

`ifdef LSU_ALIGN_CHECK_EN
    // Misaligned ldr/str fault without memory traffic.
    task automatic test_align;
        do_txn("align_ld", LDR, 16'h0003, 16'h0000, 4'h4, 0, 0);
        do_txn("align_st", STR, 16'h0005, 16'h1234, 4'h0, 0, 0);
        do_txn("align_ok", LDR, 16'h0040, 16'h0000, 4'h6, 0, 0);
    endtask
`endif

    initial begin
        test_reset;
        test_store;
        test_load_backpressure;
        test_nonmem;
        test_back_to_back;
        test_reset_midop;
`ifdef LSU_ALIGN_CHECK_EN
        test_align;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
